core_run_ctrl: RTL and testbench

//   Synthesizable run/step controller for the single-cycle processor core. Takes host

---
 rtl/core_run_ctrl.sv | 158 +++++++++++++++
 tb/tb_core_run_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/step controller sitting between the debug host and the
// processor core enable. Host commands (CLEAR, STEP, RUN N, HALT) arrive over a
// valid/ready handshake; the controller gates the core enable so the core
// advances exactly the commanded number of clocks, counts retired cycles and
// stops when the core reports a halt.
module core_run_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic             core_halt_i,
  output logic             core_en_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             done_o,
  output logic             cmd_err_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_HALT  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] retiredCnt_q, retiredCnt_d;
  logic             coreEn_q, coreEn_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             done_q, done_d;
  logic             cmdErr_q, cmdErr_d;
  logic             accept;
  logic             clearRetired;

  // Commands are never stalled: illegal ones are accepted and flagged instead.
  assign cmd_ready_o = 1'b1;
  assign accept      = cmd_valid_i && cmd_ready_o;

  // Next-state decode: command handling, run-length tracking and halt priority.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    done_d       = 1'b0;
    cmdErr_d     = 1'b0;
    clearRetired = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op_i)
            OP_CLEAR: clearRetired = 1'b1;
            OP_STEP:  state_d = ST_STEP;
            OP_RUN: begin
              state_d     = ST_RUN;
              remaining_d = cmd_count_i;
            end
            default: ;
          endcase
        end
      end

      ST_STEP, ST_RUN: begin
        // Anything but HALT while the core is running is rejected.
        if (accept && (cmd_op_i != OP_HALT)) begin
          cmdErr_d = 1'b1;
        end
        // A zero count means free-run, so the counter only moves when loaded.
        if ((state_q == ST_RUN) && (remaining_q != '0)) begin
          remaining_d = remaining_q - CNT_ONE;
        end
        if (core_halt_i && coreEn_q) begin
          state_d     = ST_HALTED;
          remaining_d = '0;
          done_d      = 1'b1;
        end else if ((accept && (cmd_op_i == OP_HALT)) ||
                     (state_q == ST_STEP) ||
                     (remaining_q == CNT_ONE)) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
          done_d      = 1'b1;
        end
      end

      ST_HALTED: begin
        if (accept) begin
          case (cmd_op_i)
            OP_CLEAR: begin
              state_d      = ST_IDLE;
              clearRetired = 1'b1;
            end
            OP_STEP, OP_RUN: cmdErr_d = 1'b1;
            default: ;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase

    coreEn_d = (state_d == ST_STEP) || (state_d == ST_RUN);
    busy_d   = coreEn_d;
    halted_d = (state_d == ST_HALTED);

    if (clearRetired) begin
      retiredCnt_d = '0;
    end else if (coreEn_q && (retiredCnt_q != CNT_MAX)) begin
      retiredCnt_d = retiredCnt_q + CNT_ONE;
    end else begin
      retiredCnt_d = retiredCnt_q;
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      retiredCnt_q <= '0;
      coreEn_q     <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      done_q       <= 1'b0;
      cmdErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      retiredCnt_q <= retiredCnt_d;
      coreEn_q     <= coreEn_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      done_q       <= done_d;
      cmdErr_q     <= cmdErr_d;
    end
  end

  assign core_en_o     = coreEn_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign done_o        = done_q;
  assign cmd_err_o     = cmdErr_q;
  assign retired_cnt_o = retiredCnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: self-checking bench for core_run_ctrl. A 16-bit instance is
// driven by directed sequences, a vector table and random traffic, all tracked
// by a command-level reference model; a 4-bit instance covers saturation.
module tb_core_run_ctrl;

  localparam bit [1:0] OP_CLEAR = 2'd0;
  localparam bit [1:0] OP_STEP  = 2'd1;
  localparam bit [1:0] OP_RUN   = 2'd2;
  localparam bit [1:0] OP_HALT  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmdValid = 1'b0;
  logic [1:0]  cmdOp = 2'd0;
  logic [15:0] cmdCount = 16'd0;
  logic        coreHalt = 1'b0;
  logic        cmdReady, coreEn, busy, halted, done, cmdErr;
  logic [15:0] retiredCnt;

  logic        nValid = 1'b0;
  logic [1:0]  nOp = 2'd0;
  logic [3:0]  nCount = 4'd0;
  logic        nHalt = 1'b0;
  logic        nReady, nEn, nBusy, nHalted, nDone, nErr;
  logic [3:0]  nRetired;

  int checksTotal = 0;
  int checksPassed = 0;

  // Reference model: STEP is treated as a RUN of length one.
  int mMode = 0;        // 0 idle, 1 active, 2 halted
  int mLeft = 0;
  bit mFree = 1'b0;
  int mRetired = 0;
  bit mEn = 1'b0;
  bit mDone = 1'b0;
  bit mErr = 1'b0;

  typedef struct {
    bit       v;
    bit [1:0] op;
    int       cnt;
    bit       ch;
    bit       expEn;
    bit       expHalted;
    bit       expDone;
    bit       expErr;
    int       expRet;
  } vec_t;

  vec_t vecs[28];

  core_run_ctrl #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady),
    .cmd_op_i(cmdOp), .cmd_count_i(cmdCount), .core_halt_i(coreHalt),
    .core_en_o(coreEn), .busy_o(busy), .halted_o(halted), .done_o(done),
    .cmd_err_o(cmdErr), .retired_cnt_o(retiredCnt)
  );

  core_run_ctrl #(.CNT_W(4)) dutNarrow (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(nValid), .cmd_ready_o(nReady),
    .cmd_op_i(nOp), .cmd_count_i(nCount), .core_halt_i(nHalt),
    .core_en_o(nEn), .busy_o(nBusy), .halted_o(nHalted), .done_o(nDone),
    .cmd_err_o(nErr), .retired_cnt_o(nRetired)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic vec_t mkVec(bit v, bit [1:0] op, int cnt, bit ch,
                                 bit en, bit hl, bit dn, bit er, int ret);
    vec_t r;
    r.v = v; r.op = op; r.cnt = cnt; r.ch = ch;
    r.expEn = en; r.expHalted = hl; r.expDone = dn; r.expErr = er; r.expRet = ret;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checksTotal++;
    if (actual == expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mMode = 0; mLeft = 0; mFree = 1'b0; mRetired = 0;
    mEn = 1'b0; mDone = 1'b0; mErr = 1'b0;
  endtask

  task automatic modelEdge(input bit v, input bit [1:0] op, input int cnt, input bit ch);
    mDone = 1'b0;
    mErr  = 1'b0;
    if (mEn) mRetired++;
    if (mMode == 1) begin
      if (v && op != OP_HALT) mErr = 1'b1;
      if (!mFree) mLeft--;
      if (ch) begin
        mMode = 2; mDone = 1'b1;
      end else if ((v && op == OP_HALT) || (!mFree && mLeft == 0)) begin
        mMode = 0; mDone = 1'b1;
      end
    end else if (v) begin
      if (mMode == 0) begin
        case (op)
          OP_CLEAR: mRetired = 0;
          OP_STEP: begin mMode = 1; mLeft = 1; mFree = 1'b0; end
          OP_RUN: begin mMode = 1; mLeft = cnt; mFree = (cnt == 0); end
          default: ;
        endcase
      end else begin
        case (op)
          OP_CLEAR: begin mMode = 0; mRetired = 0; end
          OP_STEP, OP_RUN: mErr = 1'b1;
          default: ;
        endcase
      end
    end
    mEn = (mMode == 1);
  endtask

  // One clock of the wide instance: drive, let the edge happen, compare to model.
  task automatic applyStimulus(input bit v, input bit [1:0] op, input int cnt, input bit ch);
    int expRet;
    cmdValid = v; cmdOp = op; cmdCount = 16'(cnt); coreHalt = ch;
    @(posedge clk);
    modelEdge(v, op, cnt, ch);
    @(negedge clk);
    expRet = (mRetired > 65535) ? 65535 : mRetired;
    checkOutput("model.flags", int'({coreEn, busy, halted, done, cmdErr, cmdReady}),
                int'({mEn, mEn, (mMode == 2), mDone, mErr, 1'b1}));
    checkOutput("model.retired", int'(retiredCnt), expRet);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, OP_CLEAR, 0, 1'b0);
  endtask

  task automatic applyNarrow(input bit v, input bit [1:0] op, input int cnt);
    nValid = v; nOp = op; nCount = 4'(cnt);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int enCount;

    vecs[0]  = mkVec(1, OP_CLEAR, 0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mkVec(1, OP_STEP,  0,  0, 1, 0, 0, 0, 0);
    vecs[2]  = mkVec(0, OP_CLEAR, 0,  0, 0, 0, 1, 0, 1);
    vecs[3]  = mkVec(0, OP_CLEAR, 0,  0, 0, 0, 0, 0, 1);
    vecs[4]  = mkVec(0, OP_CLEAR, 0,  0, 0, 0, 0, 0, 1);
    vecs[5]  = mkVec(1, OP_STEP,  0,  0, 1, 0, 0, 0, 1);
    vecs[6]  = mkVec(0, OP_CLEAR, 0,  0, 0, 0, 1, 0, 2);
    vecs[7]  = mkVec(0, OP_CLEAR, 0,  0, 0, 0, 0, 0, 2);
    vecs[8]  = mkVec(0, OP_CLEAR, 0,  0, 0, 0, 0, 0, 2);
    vecs[9]  = mkVec(1, OP_STEP,  0,  0, 1, 0, 0, 0, 2);
    vecs[10] = mkVec(0, OP_CLEAR, 0,  0, 0, 0, 1, 0, 3);
    vecs[11] = mkVec(0, OP_CLEAR, 0,  0, 0, 0, 0, 0, 3);
    vecs[12] = mkVec(1, OP_HALT,  0,  0, 0, 0, 0, 0, 3);
    vecs[13] = mkVec(1, OP_STEP,  0,  0, 1, 0, 0, 0, 3);
    vecs[14] = mkVec(1, OP_HALT,  0,  0, 0, 0, 1, 0, 4);
    vecs[15] = mkVec(0, OP_CLEAR, 0,  0, 0, 0, 0, 0, 4);
    vecs[16] = mkVec(1, OP_RUN,   10, 0, 1, 0, 0, 0, 4);
    vecs[17] = mkVec(0, OP_CLEAR, 0,  0, 1, 0, 0, 0, 5);
    vecs[18] = mkVec(0, OP_CLEAR, 0,  0, 1, 0, 0, 0, 6);
    vecs[19] = mkVec(0, OP_CLEAR, 0,  0, 1, 0, 0, 0, 7);
    vecs[20] = mkVec(0, OP_CLEAR, 0,  1, 0, 1, 1, 0, 8);
    vecs[21] = mkVec(0, OP_CLEAR, 0,  0, 0, 1, 0, 0, 8);
    vecs[22] = mkVec(1, OP_STEP,  0,  0, 0, 1, 0, 1, 8);
    vecs[23] = mkVec(1, OP_HALT,  0,  0, 0, 1, 0, 0, 8);
    vecs[24] = mkVec(1, OP_RUN,   5,  0, 0, 1, 0, 1, 8);
    vecs[25] = mkVec(0, OP_CLEAR, 0,  1, 0, 1, 0, 0, 8);
    vecs[26] = mkVec(1, OP_CLEAR, 0,  0, 0, 0, 0, 0, 0);
    vecs[27] = mkVec(0, OP_CLEAR, 0,  0, 0, 0, 0, 0, 0);

    // Reset state, held across two edges and then released.
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset.flags", int'({coreEn, busy, halted, done, cmdErr}), 0);
    checkOutput("reset.retired", int'(retiredCnt), 0);

    // RUN 17: enable for exactly 17 cycles, done in the 18th.
    enCount = 0;
    applyStimulus(1'b1, OP_RUN, 17, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      if (coreEn) enCount++;
      checkOutput("run17.en", int'(coreEn), int'(c <= 17));
      checkOutput("run17.done", int'(done), int'(c == 18));
      idle(1);
    end
    checkOutput("run17.enCount", enCount, 17);
    checkOutput("run17.retired", int'(retiredCnt), 17);
    checkOutput("run17.busy", int'(busy), 0);

    // Table: spaced STEPs, HALT in IDLE/STEP, RUN stopped by core_halt, HALTED exits.
    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].v, vecs[i].op, vecs[i].cnt, vecs[i].ch);
      checkOutput($sformatf("vec%0d.en", i), int'(coreEn), int'(vecs[i].expEn));
      checkOutput($sformatf("vec%0d.halted", i), int'(halted), int'(vecs[i].expHalted));
      checkOutput($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].expDone));
      checkOutput($sformatf("vec%0d.err", i), int'(cmdErr), int'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d.retired", i), int'(retiredCnt), vecs[i].expRet);
    end

    // Free-run stopped by HALT five cycles later, with a rejected STEP mid-run.
    enCount = 0;
    applyStimulus(1'b1, OP_RUN, 0, 1'b0);
    if (coreEn) enCount++;
    idle(1);
    if (coreEn) enCount++;
    idle(1);
    if (coreEn) enCount++;
    applyStimulus(1'b1, OP_STEP, 0, 1'b0);
    if (coreEn) enCount++;
    checkOutput("freerun.stepErr", int'(cmdErr), 1);
    checkOutput("freerun.stillEn", int'(coreEn), 1);
    idle(1);
    if (coreEn) enCount++;
    checkOutput("freerun.errCleared", int'(cmdErr), 0);
    applyStimulus(1'b1, OP_HALT, 0, 1'b0);
    if (coreEn) enCount++;
    checkOutput("freerun.enCount", enCount, 5);
    checkOutput("freerun.done", int'(done), 1);
    checkOutput("freerun.busy", int'(busy), 0);
    checkOutput("freerun.noErr", int'(cmdErr), 0);
    checkOutput("freerun.retired", int'(retiredCnt), 5);
    idle(1);
    checkOutput("freerun.doneOnce", int'(done), 0);

    // Asynchronous reset mid-run drops everything before the next edge.
    applyStimulus(1'b1, OP_RUN, 20, 1'b0);
    idle(6);
    checkOutput("areset.preEn", int'(coreEn), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset.flags", int'({coreEn, busy, halted, done, cmdErr}), 0);
    checkOutput("areset.retired", int'(retiredCnt), 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    enCount = 0;
    applyStimulus(1'b1, OP_RUN, 2, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (coreEn) enCount++;
      idle(1);
    end
    checkOutput("areset.run2Count", enCount, 2);
    checkOutput("areset.run2Retired", int'(retiredCnt), 2);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 6), $urandom_range(0, 15) == 0);
    end

    // 4-bit instance: saturating retire count, then HALT on the final RUN cycle.
    applyNarrow(1'b1, OP_CLEAR, 0);
    applyNarrow(1'b1, OP_RUN, 0);
    for (int i = 1; i <= 20; i++) begin
      applyNarrow(1'b0, OP_CLEAR, 0);
      if (i == 14) checkOutput("narrow.ret14", int'(nRetired), 14);
      if (i == 15) checkOutput("narrow.ret15", int'(nRetired), 15);
      if (i == 16) checkOutput("narrow.sat16", int'(nRetired), 15);
    end
    checkOutput("narrow.stillEn", int'(nEn), 1);
    applyNarrow(1'b1, OP_HALT, 0);
    checkOutput("narrow.haltFlags", int'({nEn, nBusy, nHalted, nDone, nErr, nReady}),
                int'(6'b000101));
    checkOutput("narrow.satFinal", int'(nRetired), 15);
    applyNarrow(1'b1, OP_CLEAR, 0);
    checkOutput("narrow.cleared", int'(nRetired), 0);
    applyNarrow(1'b1, OP_RUN, 3);
    applyNarrow(1'b0, OP_CLEAR, 0);
    applyNarrow(1'b0, OP_CLEAR, 0);
    checkOutput("narrow.run3En", int'(nEn), 1);
    applyNarrow(1'b1, OP_HALT, 0);
    checkOutput("narrow.lastHaltDone", int'(nDone), 1);
    checkOutput("narrow.lastHaltErr", int'(nErr), 0);
    checkOutput("narrow.lastHaltEn", int'(nEn), 0);
    checkOutput("narrow.run3Retired", int'(nRetired), 3);
    applyNarrow(1'b0, OP_CLEAR, 0);
    checkOutput("narrow.singleDone", int'({nDone, nErr}), 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
